// File: rtl/note_stream_player.sv
// Song-note streamer: prefetches a window of notes from an external song ROM,
// then shifts one new note in per tempo interval until the terminator reaches the front.
module note_stream_player #(
  parameter int unsigned NOTE_BITS      = 7,
  parameter int unsigned WINDOW         = 5,
  parameter int unsigned ADDR_BITS      = 10,
  parameter int unsigned CHOICE_BITS    = 2,
  parameter int unsigned SONG_STRIDE    = 250,
  parameter int unsigned TICKS_PER_NOTE = 50_000_000,
  parameter int unsigned ROM_LATENCY    = 2,
  parameter logic [NOTE_BITS-1:0] END_NOTE = '1
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          start,
  input  logic [CHOICE_BITS-1:0]        song_choice,
  input  logic                          pause,
  output logic [ADDR_BITS-1:0]          rom_addr,
  input  logic [NOTE_BITS-1:0]          rom_data,
  output logic [WINDOW*NOTE_BITS-1:0]   notes,
  output logic                          notes_valid,
  output logic                          note_tick,
  output logic                          busy,
  output logic                          done,
  output logic [1:0]                    state_out
);

  localparam int unsigned NOTES_W = WINDOW * NOTE_BITS;
  localparam int unsigned CNT_W   = (TICKS_PER_NOTE > 1) ? $clog2(TICKS_PER_NOTE) : 1;
  localparam int unsigned WAIT_W  = $clog2(ROM_LATENCY + 1);
  localparam int unsigned FILL_W  = $clog2(WINDOW + 1);

  localparam logic [ADDR_BITS-1:0] STRIDE_A  = ADDR_BITS'(SONG_STRIDE);
  localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(TICKS_PER_NOTE - 1);
  localparam logic [WAIT_W-1:0]    WAIT_LAST = WAIT_W'(ROM_LATENCY - 1);
  localparam logic [FILL_W-1:0]    FILL_LAST = FILL_W'(WINDOW - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PREFILL = 2'd1;
  localparam logic [1:0] S_PLAY    = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [NOTES_W-1:0]   notes_q, notes_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [ADDR_BITS-1:0] limit_q, limit_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic                 tick_q, tick_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [ADDR_BITS-1:0] base_c;
  logic                 at_limit_c;
  logic [NOTE_BITS-1:0] shift_note_c;
  logic [NOTE_BITS-1:0] msb_note_c;
  logic                 do_shift_c;

  // Song base truncated to the address width, as the ROM map wraps.
  assign base_c       = ADDR_BITS'(STRIDE_A * ADDR_BITS'(song_choice));
  assign at_limit_c   = (addr_q >= limit_q);
  assign shift_note_c = at_limit_c ? END_NOTE : rom_data;
  assign msb_note_c   = notes_q[NOTES_W-1 -: NOTE_BITS];

  always_comb begin
    state_d    = state_q;
    notes_d    = notes_q;
    addr_d     = addr_q;
    limit_d    = limit_q;
    cnt_d      = cnt_q;
    wait_d     = wait_q;
    fill_d     = fill_q;
    tick_d     = 1'b0;
    do_shift_c = 1'b0;

    if (start) begin
      state_d = S_PREFILL;
      notes_d = '0;
      addr_d  = base_c;
      limit_d = base_c + STRIDE_A;
      cnt_d   = '0;
      wait_d  = '0;
      fill_d  = '0;
    end else begin
      case (state_q)
        S_PREFILL: begin
          if (wait_q == WAIT_LAST) begin
            wait_d     = '0;
            do_shift_c = 1'b1;
            fill_d     = fill_q + FILL_W'(1);
            if (fill_q == FILL_LAST) state_d = S_PLAY;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
        S_PLAY: begin
          // Terminator at the front ends playback regardless of pause.
          if (msb_note_c == END_NOTE) begin
            state_d = S_DONE;
          end else if (!pause) begin
            if (cnt_q == CNT_LAST) begin
              cnt_d      = '0;
              do_shift_c = 1'b1;
              tick_d     = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end

    if (do_shift_c) begin
      notes_d = {notes_q[NOTES_W-NOTE_BITS-1:0], shift_note_c};
      addr_d  = at_limit_c ? limit_q : addr_q + ADDR_BITS'(1);
    end

    valid_d = (state_d == S_PLAY) || (state_d == S_DONE);
    busy_d  = (state_d == S_PREFILL) || (state_d == S_PLAY);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      notes_q <= '0;
      addr_q  <= '0;
      limit_q <= '0;
      cnt_q   <= '0;
      wait_q  <= '0;
      fill_q  <= '0;
      tick_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      notes_q <= notes_d;
      addr_q  <= addr_d;
      limit_q <= limit_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      fill_q  <= fill_d;
      tick_q  <= tick_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign rom_addr    = addr_q;
  assign notes       = notes_q;
  assign notes_valid = valid_q;
  assign note_tick   = tick_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign state_out   = state_q;

endmodule

// File: tb/tb_note_stream_player.sv
// Bench for note_stream_player: directed scenarios plus randomized songs and pause
// patterns checked against a note-sequence / tick-count reference model.
module tb_note_stream_player;

  localparam int unsigned STRIDE = 16;
  localparam int unsigned TPN    = 8;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  song_choice = 2'd0;
  logic        pause = 1'b0;
  logic [9:0]  rom_addr;
  logic [6:0]  rom_data;
  logic [34:0] notes;
  logic        notes_valid, note_tick, busy, done;
  logic [1:0]  state_out;

  logic [6:0]  rom_mem [0:1023];
  logic [9:0]  rom_stage = 10'd0;

  int errors = 0;
  int checks = 0;

  note_stream_player #(
    .NOTE_BITS(7), .WINDOW(5), .ADDR_BITS(10), .CHOICE_BITS(2),
    .SONG_STRIDE(STRIDE), .TICKS_PER_NOTE(TPN), .ROM_LATENCY(2)
  ) dut (
    .clk_in(clk), .rst_in(rst_in), .start(start), .song_choice(song_choice),
    .pause(pause), .rom_addr(rom_addr), .rom_data(rom_data), .notes(notes),
    .notes_valid(notes_valid), .note_tick(note_tick), .busy(busy), .done(done),
    .state_out(state_out)
  );

  always #5 clk = ~clk;

  // Two-cycle ROM: one address stage, data valid in the second cycle after an address change.
  always @(posedge clk) rom_stage <= rom_addr;
  assign rom_data = rom_mem[rom_stage];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [34:0] win5(input int a0);
    logic [34:0] w = '0;
    for (int j = 0; j < 5; j++) w = {w[27:0], 7'(a0 + j)};
    return w;
  endfunction

  // Note at position i of a song: ROM contents inside the song range, terminator beyond it.
  function automatic logic [6:0] ref_note(input int b, input int i);
    if (i >= int'(STRIDE)) return 7'h7F;
    return rom_mem[b + i];
  endfunction

  // Window after s total shifts: LSB holds note s-1, MSB holds note s-5, empty slots zero.
  function automatic logic [34:0] ref_window(input int b, input int s);
    logic [34:0] w = '0;
    for (int j = 0; j < 5; j++) begin
      int idx = s - 5 + j;
      w = {w[27:0], (idx < 0) ? 7'd0 : ref_note(b, idx)};
    end
    return w;
  endfunction

  task automatic test_reset();
    rst_in = 1'b1;
    repeat (3) step();
    checks++; if (notes !== 35'd0) begin errors++; $display("FAIL reset_notes got=%h exp=0", notes); end
    checks++; if (rom_addr !== 10'd0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", rom_addr); end
    checks++; if (state_out !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state_out); end
    checks++;
    if ({notes_valid, busy, done, note_tick} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got=%b exp=0000", {notes_valid, busy, done, note_tick});
    end
    rst_in = 1'b0;
    step();
  endtask

  task automatic test_prefill();
    song_choice = 2'd1;
    start = 1'b1; step(); start = 1'b0;
    checks++; if (rom_addr !== 10'd16) begin errors++; $display("FAIL prefill_base got=%0d exp=16", rom_addr); end
    checks++; if (state_out !== 2'd1 || busy !== 1'b1) begin errors++; $display("FAIL prefill_state got=%0d/%b exp=1/1", state_out, busy); end
    repeat (9) step();
    checks++; if (notes_valid !== 1'b0) begin errors++; $display("FAIL prefill_valid_early got=%b exp=0", notes_valid); end
    step();
    checks++; if (notes_valid !== 1'b1) begin errors++; $display("FAIL prefill_valid got=%b exp=1", notes_valid); end
    checks++; if (notes !== win5(16)) begin errors++; $display("FAIL prefill_window got=%h exp=%h", notes, win5(16)); end
    checks++; if (rom_addr !== 10'd21) begin errors++; $display("FAIL prefill_addr got=%0d exp=21", rom_addr); end
    checks++; if (state_out !== 2'd2) begin errors++; $display("FAIL prefill_play got=%0d exp=2", state_out); end
  endtask

  task automatic test_play_pause();
    int n;
    repeat (7) step();
    checks++; if (note_tick !== 1'b0) begin errors++; $display("FAIL tick_early got=%b exp=0", note_tick); end
    step();
    checks++; if (note_tick !== 1'b1) begin errors++; $display("FAIL tick1 got=%b exp=1", note_tick); end
    checks++; if (notes !== win5(17)) begin errors++; $display("FAIL tick1_window got=%h exp=%h", notes, win5(17)); end
    repeat (8) step();
    checks++; if (note_tick !== 1'b1) begin errors++; $display("FAIL tick2 got=%b exp=1", note_tick); end
    checks++; if (notes !== win5(18)) begin errors++; $display("FAIL tick2_window got=%h exp=%h", notes, win5(18)); end
    n = 27;
    repeat (2) begin step(); n++; end
    pause = 1'b1;
    repeat (5) begin step(); n++; end
    pause = 1'b0;
    while (note_tick !== 1'b1 && n < 60) begin step(); n++; end
    checks++; if (n != 40) begin errors++; $display("FAIL pause_delay got_cycle=%0d exp=40", n); end
    checks++; if (notes !== win5(19)) begin errors++; $display("FAIL pause_window got=%h exp=%h", notes, win5(19)); end
  endtask

  task automatic test_terminator();
    int n, ticks, last_tick, changed;
    logic [6:0]  prev_msb;
    logic [34:0] frozen_notes;
    logic [9:0]  frozen_addr;
    rom_mem[23] = 7'h7F;
    song_choice = 2'd1;
    start = 1'b1; step(); start = 1'b0;
    n = 1; ticks = 0; last_tick = -1; prev_msb = 7'd0;
    while (done !== 1'b1 && n < 300) begin
      if (note_tick === 1'b1) begin ticks++; last_tick = n; end
      prev_msb = notes[34:28];
      step(); n++;
    end
    checks++; if (ticks != 7) begin errors++; $display("FAIL term_ticks got=%0d exp=7", ticks); end
    checks++; if (prev_msb !== 7'h7F) begin errors++; $display("FAIL term_msb got=%h exp=7f", prev_msb); end
    checks++; if (n != 68 || last_tick != 67) begin errors++; $display("FAIL term_done_cycle got=%0d/%0d exp=68/67", n, last_tick); end
    checks++; if (busy !== 1'b0 || state_out !== 2'd3) begin errors++; $display("FAIL term_state got=%b/%0d exp=0/3", busy, state_out); end
    frozen_notes = notes; frozen_addr = rom_addr; ticks = 0; changed = 0;
    repeat (20) begin
      step();
      if (note_tick === 1'b1) ticks++;
      if (notes !== frozen_notes || rom_addr !== frozen_addr || done !== 1'b1) changed++;
    end
    checks++; if (ticks != 0 || changed != 0) begin errors++; $display("FAIL done_absorb got=%0d/%0d exp=0/0", ticks, changed); end
    rom_mem[23] = 7'd23;
  endtask

  task automatic test_bound();
    int n, ticks, max_addr;
    song_choice = 2'd0;
    start = 1'b1; step(); start = 1'b0;
    n = 1; ticks = 0; max_addr = 0;
    while (done !== 1'b1 && n < 400) begin
      if (note_tick === 1'b1) ticks++;
      if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
      step(); n++;
    end
    checks++; if (ticks != 16 || n != 140) begin errors++; $display("FAIL bound_done got=%0d ticks cyc %0d exp=16 cyc 140", ticks, n); end
    checks++; if (rom_addr !== 10'd16 || max_addr != 16) begin errors++; $display("FAIL bound_addr got=%0d max %0d exp=16", rom_addr, max_addr); end
    checks++; if (notes !== {35{1'b1}}) begin errors++; $display("FAIL bound_window got=%h exp=all ones", notes); end
  endtask

  task automatic test_restart_and_reset();
    song_choice = 2'd1;
    start = 1'b1; step(); start = 1'b0;
    repeat (19) step();
    song_choice = 2'd2; pause = 1'b1; start = 1'b1;
    step();
    start = 1'b0; pause = 1'b0;
    checks++; if (notes !== 35'd0) begin errors++; $display("FAIL restart_notes got=%h exp=0", notes); end
    checks++; if (rom_addr !== 10'd32) begin errors++; $display("FAIL restart_addr got=%0d exp=32", rom_addr); end
    checks++;
    if (state_out !== 2'd1 || notes_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL restart_state got=%0d/%b/%b exp=1/0/1", state_out, notes_valid, busy);
    end
    repeat (2) step();
    rst_in = 1'b1; step(); rst_in = 1'b0;
    checks++;
    if (notes !== 35'd0 || rom_addr !== 10'd0 || state_out !== 2'd0 ||
        {notes_valid, busy, done, note_tick} !== 4'b0000) begin
      errors++; $display("FAIL midreset got notes=%h addr=%0d st=%0d exp all zero", notes, rom_addr, state_out);
    end
    repeat (3) step();
    checks++; if (state_out !== 2'd0 || rom_addr !== 10'd0) begin errors++; $display("FAIL idle_hold got=%0d/%0d exp=0/0", state_out, rom_addr); end
  endtask

  task automatic test_random(input int iters);
    int b, n, s, u, phase, post, pos;
    logic p, tick_exp;
    logic [34:0] exp_notes;
    logic [9:0]  exp_addr;
    logic [2:0]  exp_flags;
    for (int it = 0; it < iters; it++) begin
      song_choice = 2'($urandom_range(0, 3));
      b = 16 * int'(song_choice);
      for (int i = 0; i < 16; i++) rom_mem[b + i] = 7'($urandom_range(0, 126));
      if ($urandom_range(0, 2) != 0) begin
        pos = $urandom_range(0, 15);
        rom_mem[b + pos] = 7'h7F;
      end
      pause = 1'($urandom_range(0, 1));
      start = 1'b1; step(); start = 1'b0;
      n = 1; s = 0; u = 0; phase = 1; post = 0; tick_exp = 1'b0;
      while (post < 4 && n < 400) begin
        exp_notes = ref_window(b, s);
        exp_addr  = 10'(b + ((s < 16) ? s : 16));
        exp_flags = {phase >= 2, (phase == 1) || (phase == 2), phase == 3};
        checks++; if (notes !== exp_notes) begin errors++; $display("FAIL rnd_notes it=%0d cyc=%0d got=%h exp=%h", it, n, notes, exp_notes); end
        checks++; if (rom_addr !== exp_addr) begin errors++; $display("FAIL rnd_addr it=%0d cyc=%0d got=%0d exp=%0d", it, n, rom_addr, exp_addr); end
        checks++; if (state_out !== 2'(phase)) begin errors++; $display("FAIL rnd_state it=%0d cyc=%0d got=%0d exp=%0d", it, n, state_out, phase); end
        checks++; if (note_tick !== tick_exp) begin errors++; $display("FAIL rnd_tick it=%0d cyc=%0d got=%b exp=%b", it, n, note_tick, tick_exp); end
        checks++; if ({notes_valid, busy, done} !== exp_flags) begin errors++; $display("FAIL rnd_flags it=%0d cyc=%0d got=%b exp=%b", it, n, {notes_valid, busy, done}, exp_flags); end
        p = ($urandom_range(0, 3) == 0);
        pause = p;
        tick_exp = 1'b0;
        if (phase == 1) begin
          if (n % 2 == 0) s++;
          if (s == 5) phase = 2;
        end else if (phase == 2) begin
          if (ref_note(b, s - 5) == 7'h7F) phase = 3;
          else if (!p) begin
            u++;
            if (u == int'(TPN)) begin u = 0; s++; tick_exp = 1'b1; end
          end
        end else begin
          post++;
        end
        step(); n++;
      end
      checks++; if (phase != 3) begin errors++; $display("FAIL rnd_timeout it=%0d got_phase=%0d exp=3", it, phase); end
    end
    pause = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) rom_mem[a] = 7'(a & 63);
    test_reset();
    test_prefill();
    test_play_pause();
    test_terminator();
    test_bound();
    test_restart_and_reset();
    test_random(12);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
